// File: rtl/wb_arbiter.sv
`default_nettype none
// wb_arbiter: per-unit result FIFOs (alu/sfu/bru/agu) arbitrated round-robin onto NPORTS writeback ports.
// Optional macro WB_BYPASS_EN: an empty unit's live input competes directly. Rev 1.0
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int NPORTS = 2,
  parameter int DW     = 32,
  parameter int PRW    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  recover,
  input  logic                  alu_valid,
  input  logic [DW-1:0]         alu_out,
  input  logic [PRW-1:0]        alu_rd,
  output logic                  alu_ready,
  input  logic                  sfu_valid,
  input  logic [DW-1:0]         sfu_out,
  input  logic [PRW-1:0]        sfu_rd,
  output logic                  sfu_ready,
  input  logic                  agu_valid,
  input  logic [DW-1:0]         agu_out,
  input  logic [PRW-1:0]        agu_rd,
  output logic                  agu_ready,
  input  logic                  bru_valid,
  input  logic [DW-1:0]         bru_out,
  input  logic [PRW-1:0]        bru_rd,
  output logic                  bru_ready,
  input  logic                  bru_pright,
  input  logic                  bru_btype,
  input  logic                  bru_rdc,
  input  logic [31:0]           bru_raddr,
  output logic [NPORTS-1:0]     wb_en,
  output logic [NPORTS*PRW-1:0] wb_rd,
  output logic [NPORTS*DW-1:0]  wb_data,
  output logic                  br_valid,
  output logic                  br_pright,
  output logic                  br_btype,
  output logic                  br_rdc,
  output logic [31:0]           br_raddr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DW + PRW;
  localparam int BW = 35;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [EW-1:0] r_mem [4][DEPTH];
  logic [BW-1:0] r_bmem [DEPTH];
  logic [AW-1:0] r_rp [4];
  logic [AW-1:0] r_wp [4];
  logic [CW-1:0] r_cnt [4];
  logic [1:0]    r_rr;

  logic [3:0]    w_in_valid;
  logic [EW-1:0] w_in_ent [4];
  logic [BW-1:0] w_bin;
  logic [3:0]    w_ready, w_empty, w_cand, w_gnt, w_enq, w_deq;
  logic [EW-1:0] w_src [4];
  logic [BW-1:0] w_bsrc;
  logic [3:0]    w_port_en;
  logic [1:0]    w_port_unit [4];
  logic [1:0]    w_nxt_rr;
  logic [2:0]    w_n;
  logic [1:0]    w_idx;

  // Unit index order matches the round-robin order: 0=alu, 1=sfu, 2=bru, 3=agu.
  assign w_in_valid  = {agu_valid, bru_valid, sfu_valid, alu_valid};
  assign w_in_ent[0] = {alu_out, alu_rd};
  assign w_in_ent[1] = {sfu_out, sfu_rd};
  assign w_in_ent[2] = {bru_out, bru_rd};
  assign w_in_ent[3] = {agu_out, agu_rd};
  assign w_bin       = {bru_pright, bru_btype, bru_rdc, bru_raddr};

  assign alu_ready = w_ready[0];
  assign sfu_ready = w_ready[1];
  assign bru_ready = w_ready[2];
  assign agu_ready = w_ready[3];

  always_comb begin
    for (int u = 0; u < 4; u++) begin
      w_empty[u] = (r_cnt[u] == '0);
      w_ready[u] = (r_cnt[u] != CW'(DEPTH)) && !reset;
      w_cand[u]  = !w_empty[u] || (BYPASS && w_in_valid[u]);
      w_src[u]   = (BYPASS && w_empty[u]) ? w_in_ent[u] : r_mem[u][r_rp[u]];
    end
    w_bsrc = (BYPASS && w_empty[2]) ? w_bin : r_bmem[r_rp[2]];
  end

  always_comb begin
    w_n       = '0;
    w_idx     = '0;
    w_gnt     = '0;
    w_port_en = '0;
    w_nxt_rr  = r_rr;
    for (int p = 0; p < 4; p++) w_port_unit[p] = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_rr + 2'(i);
      if (w_cand[w_idx] && (w_n < 3'(NPORTS))) begin
        w_gnt[w_idx]            = 1'b1;
        w_port_en[w_n[1:0]]     = 1'b1;
        w_port_unit[w_n[1:0]]   = w_idx;
        w_n                     = w_n + 3'd1;
        w_nxt_rr                = w_idx + 2'd1;
      end
    end
  end

  // A granted unit with an empty FIFO was bypassed, so it neither pops nor enqueues.
  always_comb begin
    for (int u = 0; u < 4; u++) begin
      w_deq[u] = w_gnt[u] && !w_empty[u] && !recover;
      w_enq[u] = w_in_valid[u] && w_ready[u] && !recover && !(w_gnt[u] && w_empty[u]);
    end
  end

  always_ff @(posedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (w_enq[u]) r_mem[u][r_wp[u]] <= w_in_ent[u];
    end
    if (w_enq[2]) r_bmem[r_wp[2]] <= w_bin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int u = 0; u < 4; u++) begin
        r_rp[u]  <= '0;
        r_wp[u]  <= '0;
        r_cnt[u] <= '0;
      end
      r_rr      <= '0;
      wb_en     <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      br_valid  <= 1'b0;
      br_pright <= 1'b0;
      br_btype  <= 1'b0;
      br_rdc    <= 1'b0;
      br_raddr  <= '0;
    end else if (recover) begin
      for (int u = 0; u < 4; u++) begin
        r_rp[u]  <= '0;
        r_wp[u]  <= '0;
        r_cnt[u] <= '0;
      end
      wb_en     <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      br_valid  <= 1'b0;
      br_pright <= 1'b0;
      br_btype  <= 1'b0;
      br_rdc    <= 1'b0;
      br_raddr  <= '0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (w_enq[u]) r_wp[u] <= r_wp[u] + AW'(1);
        if (w_deq[u]) r_rp[u] <= r_rp[u] + AW'(1);
        r_cnt[u] <= r_cnt[u] + CW'(w_enq[u]) - CW'(w_deq[u]);
      end
      r_rr <= w_nxt_rr;
      for (int p = 0; p < NPORTS; p++) begin
        wb_en[p]             <= w_port_en[p];
        wb_rd[p*PRW +: PRW]  <= w_port_en[p] ? w_src[w_port_unit[p]][PRW-1:0] : '0;
        wb_data[p*DW +: DW]  <= w_port_en[p] ? w_src[w_port_unit[p]][EW-1:PRW] : '0;
      end
      br_valid  <= w_gnt[2];
      br_pright <= w_gnt[2] & w_bsrc[34];
      br_btype  <= w_gnt[2] & w_bsrc[33];
      br_rdc    <= w_gnt[2] & w_bsrc[32];
      br_raddr  <= w_gnt[2] ? w_bsrc[31:0] : '0;
    end
  end

endmodule
`default_nettype wire
